// File: rtl/mode_display.sv
// rtl/mode_display.sv - multiplexed 4-digit seven-segment PMIC mode display with blink and frame snapshot
module mode_display #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [2:0] mode,
    input  logic       ready,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int SW = $clog2(REFRESH_DIV);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [SW-1:0] SLOT_MAX  = SW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

    localparam logic [6:0] G_BLANK = 7'b1111111;
    localparam logic [6:0] G_O     = 7'b1000000;
    localparam logic [6:0] G_F     = 7'b0001110;
    localparam logic [6:0] G_N     = 7'b0101011;
    localparam logic [6:0] G_L     = 7'b1000111;
    localparam logic [6:0] G_P     = 7'b0001100;
    localparam logic [6:0] G_B     = 7'b0000011;
    localparam logic [6:0] G_E     = 7'b0000110;
    localparam logic [6:0] G_R     = 7'b0101111;

    logic [2:0]    mode_s1_q, mode_s1_d, mode_s2_q, mode_s2_d;
    logic          ready_s1_q, ready_s1_d, ready_s2_q, ready_s2_d;
    logic [SW-1:0] slot_q, slot_d;
    logic [1:0]    idx_q, idx_d;
    logic [2:0]    snap_mode_q, snap_mode_d;
    logic          snap_ready_q, snap_ready_d;
    logic [BW-1:0] blink_q, blink_d;
    logic          phase_q, phase_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic          slot_wrap, frame_end, blank;

    function automatic logic [6:0] glyph(input logic [2:0] m, input logic [1:0] d);
        logic [6:0] g;
        g = G_BLANK;
        case (m)
            3'b000: begin
                if (d == 2'd2) g = G_O;
                else if (d != 2'd3) g = G_F;
            end
            3'b001: begin
                if (d == 2'd1) g = G_O;
                else if (d == 2'd0) g = G_N;
            end
            3'b010: begin
                if (d == 2'd1) g = G_L;
                else if (d == 2'd0) g = G_P;
            end
            3'b100: begin
                if (d == 2'd1) g = G_L;
                else if (d == 2'd0) g = G_B;
            end
            default: begin
                if (d == 2'd2) g = G_E;
                else if (d != 2'd3) g = G_R;
            end
        endcase
        return g;
    endfunction

    always_comb begin
        mode_s1_d  = mode;
        mode_s2_d  = mode_s1_q;
        ready_s1_d = ready;
        ready_s2_d = ready_s1_q;

        slot_wrap = (slot_q == SLOT_MAX);
        frame_end = slot_wrap && (idx_q == 2'd3);
        slot_d    = slot_wrap ? '0 : slot_q + 1'b1;
        idx_d     = slot_wrap ? idx_q + 2'd1 : idx_q;

        // Snapshot only at the frame boundary so one frame never shows two codes
        snap_mode_d  = frame_end ? mode_s2_q  : snap_mode_q;
        snap_ready_d = frame_end ? ready_s2_q : snap_ready_q;

        blink_d = (blink_q == BLINK_MAX) ? '0 : blink_q + 1'b1;
        phase_d = (blink_q == BLINK_MAX) ? ~phase_q : phase_q;

        // seg always carries the glyph; only the anodes are masked
        blank = (slot_q == '0) || !en || (!snap_ready_q && !phase_q);
        an_d  = blank ? 4'b1111 : ~(4'b0001 << idx_q);
        seg_d = glyph(snap_mode_q, idx_q);
        dp_d  = !((idx_q == 2'd0) && snap_ready_q && !blank);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_s1_q    <= 3'b000;
            mode_s2_q    <= 3'b000;
            ready_s1_q   <= 1'b0;
            ready_s2_q   <= 1'b0;
            slot_q       <= '0;
            idx_q        <= 2'd0;
            snap_mode_q  <= 3'b000;
            snap_ready_q <= 1'b0;
            blink_q      <= '0;
            phase_q      <= 1'b1;
            an_q         <= 4'b1111;
            seg_q        <= G_BLANK;
            dp_q         <= 1'b1;
        end else begin
            mode_s1_q    <= mode_s1_d;
            mode_s2_q    <= mode_s2_d;
            ready_s1_q   <= ready_s1_d;
            ready_s2_q   <= ready_s2_d;
            slot_q       <= slot_d;
            idx_q        <= idx_d;
            snap_mode_q  <= snap_mode_d;
            snap_ready_q <= snap_ready_d;
            blink_q      <= blink_d;
            phase_q      <= phase_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_mode_display.sv
// tb/tb_mode_display.sv - randomized scoreboard bench for mode_display against a frame-arithmetic model
module tb_mode_display;

    localparam int R  = 4;
    localparam int B  = 64;
    localparam int HN = 16384;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       en    = 1'b0;
    logic       ready = 1'b0;
    logic [2:0] mode  = 3'b000;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    always #5 clk = ~clk;

    mode_display #(.REFRESH_DIV(R), .BLINK_DIV(B)) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .mode  (mode),
        .ready (ready),
        .an    (an),
        .seg   (seg),
        .dp    (dp)
    );

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } out_t;

    out_t       exp_q[$];
    int         n = 0;
    logic [2:0] mode_h[HN];
    logic       ready_h[HN];
    int         compared   = 0;
    int         mismatched = 0;

    task automatic check(input string name, input int act, input int req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", name, act, req, n, $time);
        end
    endtask

    function automatic string mode_text(input logic [2:0] m);
        case (m)
            3'b000:  return " OFF";
            3'b001:  return "  On";
            3'b010:  return "  LP";
            3'b100:  return "  Lb";
            default: return " Err";
        endcase
    endfunction

    function automatic logic [6:0] char_seg(input byte c);
        case (c)
            "O":     return 7'b1000000;
            "F":     return 7'b0001110;
            "n":     return 7'b0101011;
            "L":     return 7'b1000111;
            "P":     return 7'b0001100;
            "b":     return 7'b0000011;
            "E":     return 7'b0000110;
            "r":     return 7'b0101111;
            default: return 7'b1111111;
        endcase
    endfunction

    // Expected outputs after an edge, given the number of edges s before it and en at the edge
    function automatic out_t model(input int s, input logic en_n);
        out_t       o;
        int         slot, idx, k;
        logic [2:0] sm;
        logic       sr, phase, blank;
        string      t;
        slot = s % R;
        idx  = (s / R) % 4;
        k    = s / (4 * R);
        if (k == 0) begin
            sm = 3'b000;
            sr = 1'b0;
        end else begin
            sm = mode_h[4 * R * k - 2];
            sr = ready_h[4 * R * k - 2];
        end
        phase = ((s / B) % 2) == 0;
        blank = (slot == 0) || !en_n || (!sr && !phase);
        t     = mode_text(sm);
        o.seg = char_seg(t[3 - idx]);
        o.an  = blank ? 4'b1111 : ~(4'b0001 << idx);
        o.dp  = !((idx == 0) && sr && !blank);
        return o;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            n++;
            if (n < HN) begin
                mode_h[n]  = mode;
                ready_h[n] = ready;
                exp_q.push_back(model(n - 1, en));
            end else begin
                mismatched++;
                $display("FAIL history: cycle %0d exceeds model depth %0d", n, HN);
            end
        end
    end

    always @(negedge clk) begin
        out_t e;
        if (reset && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("an",  int'(an),  int'(e.an));
            check("seg", int'(seg), int'(e.seg));
            check("dp",  int'(dp),  int'(e.dp));
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_an"},  int'(an),  32'hf);
        check({tag, "_seg"}, int'(seg), 32'h7f);
        check({tag, "_dp"},  int'(dp),  1);
    endtask

    task automatic hold(input logic [2:0] m, input logic r, input logic e, input int cycles);
        @(negedge clk);
        mode  = m;
        ready = r;
        en    = e;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic random_segments(input int count);
        for (int i = 0; i < count; i++) begin
            hold(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 5) != 0), $urandom_range(5, 150));
        end
    endtask

    initial begin
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        mode  = 3'b001;
        ready = 1'b1;
        en    = 1'b1;
        #2 reset = 1'b1;
        repeat (60) @(negedge clk);

        hold(3'b010, 1'b1, 1'b1, 50);
        hold(3'b100, 1'b0, 1'b1, 200);
        hold(3'b100, 1'b1, 1'b1, 40);
        hold(3'b011, 1'b1, 1'b1, 40);
        hold(3'b011, 1'b1, 1'b0, 10);
        hold(3'b011, 1'b1, 1'b1, 30);
        random_segments(30);

        @(posedge clk);
        #3 reset = 1'b0;
        exp_q.delete();
        n = 0;
        #1 check_reset_outputs("async_reset");
        @(negedge clk);
        mode  = 3'b001;
        ready = 1'b1;
        en    = 1'b1;
        #2 reset = 1'b1;
        repeat (40) @(negedge clk);
        random_segments(20);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
